// File: rtl/dmem_sram_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the data SRAM / AXI wrapper
// (slave).
//   data_req/data_wr/data_size/data_addr/data_wdata : request, master -> slave
//   data_addr_ok                                    : request accepted, slave -> master
//   data_data_ok/data_rdata                         : write done / read data, slave -> master
interface dmem_sram_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_sram_bridge.sv
// MEM-stage data-side bus master. Issues one SRAM-like transaction per memory instruction,
// stalls the pipeline until it completes, then holds load data until the instruction leaves MEM.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   mem_req/wr/size/offset    : MEM-stage access request (offset replaces addr[1:0])
//   mem_addr, mem_wdata       : effective address, lane-aligned store data
//   pipe_adv, flush           : MEM->WB advance, kill of the MEM instruction
//   mem_stall, mem_rdata      : pipeline hold, raw load word (valid in Done)
//   bus                       : SRAM-like master port
module dmem_sram_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [1:0]        mem_offset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              pipe_adv,
  input  logic              flush,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_rdata,
  dmem_sram_bridge_if.master bus
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic              req_wr_q, req_wr_d;
  logic [1:0]        req_size_q, req_size_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte offset comes from mem_offset, so the low address bits are intentionally dropped.
  logic unused_addr_lo;
  assign unused_addr_lo = ^mem_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      drop_q      <= 1'b0;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'b00;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    mem_stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_stall = mem_req && !flush;
        if (mem_req && !flush) begin
          req_wr_d    = mem_wr;
          req_size_d  = mem_size;
          req_addr_d  = {mem_addr[ADDR_W-1:2], mem_offset};
          req_wdata_d = mem_wdata;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        // Once dropped, the stall belongs to whatever new instruction is waiting in MEM.
        mem_stall = drop_q ? (mem_req && !flush) : !flush;
        // A killed request is never withdrawn; only remember to discard its response.
        if (flush) drop_d = 1'b1;
        if (bus.data_addr_ok) state_d = StData;
      end
      StData: begin
        mem_stall = drop_q ? (mem_req && !flush) : !flush;
        if (bus.data_data_ok) begin
          // A flush coinciding with the response kills it just like an earlier one.
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            if (!req_wr_q) rdata_d = bus.data_rdata;
            state_d = StDone;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      StDone: begin
        if (pipe_adv || flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.data_req   = (state_q == StAddr);
  assign bus.data_wr    = req_wr_q;
  assign bus.data_size  = req_size_q;
  assign bus.data_addr  = req_addr_q;
  assign bus.data_wdata = req_wdata_q;
  assign mem_rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed scenarios followed by randomized
// transactions, each checked against a transaction-level expectation.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_wr, pipe_adv, flush, mem_stall;
  logic [1:0]  mem_size, mem_offset;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_offset (mem_offset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .pipe_adv   (pipe_adv),
    .flush      (flush),
    .mem_stall  (mem_stall),
    .mem_rdata  (mem_rdata),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One memory instruction. a_dly: extra req cycles before addr_ok; d_dly: extra Data cycles
  // before data_ok; adv_dly: Done cycles before pipe_adv; flush_at: busy-cycle index of a flush
  // (-1 none); next_req: a new instruction sits in MEM right after the flush.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [1:0] off, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int a_dly, input int d_dly,
                         input int adv_dly, input int flush_at, input bit next_req);
    logic [31:0] exp_addr;
    bit          killed;
    bit          in_addr;
    int          stalls;
    int          busy;
    exp_addr = {addr[31:2], off};
    busy     = a_dly + d_dly + 2;
    killed   = 0;
    stalls   = 0;
    mem_req = 1'b1; mem_wr = wr; mem_size = size; mem_addr = addr; mem_offset = off;
    mem_wdata = wdata; flush = 1'b0; pipe_adv = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
    #1;
    check_eq("idle_stall", mem_stall, 1);
    check_eq("idle_req", bus.data_req, 0);
    if (mem_stall) stalls++;
    @(posedge clk); #1;
    for (int i = 0; i < busy; i++) begin
      in_addr = (i <= a_dly);
      flush   = (i == flush_at);
      if (flush) killed = 1;
      bus.data_addr_ok = in_addr && (i == a_dly);
      bus.data_data_ok = (i == busy - 1);
      bus.data_rdata   = (i == busy - 1) ? rdata : $urandom;
      #1;
      check_eq("req", bus.data_req, in_addr);
      if (in_addr) begin
        check_eq("addr", bus.data_addr, exp_addr);
        check_eq("wr", bus.data_wr, wr);
        check_eq("size", bus.data_size, size);
        check_eq("wdata", bus.data_wdata, wdata);
      end
      check_eq("busy_stall", mem_stall, !killed ? 1 : (flush ? 0 : next_req));
      check_eq("busy_rdata", mem_rdata, model_rdata);
      if (mem_stall) stalls++;
      @(posedge clk); #1;
      if (flush) begin
        flush = 1'b0;
        mem_req = next_req; mem_addr = $urandom; mem_wdata = $urandom; mem_wr = $urandom;
      end
    end
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    if (!killed) begin
      if (!wr) model_rdata = rdata;
      for (int i = 0; i <= adv_dly; i++) begin
        pipe_adv = (i == adv_dly);
        bus.data_rdata = $urandom;
        #1;
        check_eq("done_stall", mem_stall, 0);
        check_eq("done_req", bus.data_req, 0);
        check_eq("done_rdata", mem_rdata, model_rdata);
        @(posedge clk); #1;
      end
      pipe_adv = 1'b0;
      mem_req  = 1'b0;
      check_eq("stall_cycles", stalls, a_dly + d_dly + 3);
    end else begin
      #1;
      check_eq("kill_rdata", mem_rdata, model_rdata);
      check_eq("kill_req", bus.data_req, 0);
    end
  endtask

  task automatic reset_mid_data();
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'b11; mem_addr = 32'hFFFF_FFF0;
    mem_offset = 2'b10; mem_wdata = 32'hCAFE_F00D; flush = 1'b0; pipe_adv = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    mem_req = 1'b0;
    #1;
    check_eq("pre_rst_addr", bus.data_addr, 32'hFFFF_FFF2);
    rst = 1'b1;
    #1;
    check_eq("arst_req", bus.data_req, 0);
    check_eq("arst_wr", bus.data_wr, 0);
    check_eq("arst_size", bus.data_size, 0);
    check_eq("arst_addr", bus.data_addr, 0);
    check_eq("arst_wdata", bus.data_wdata, 0);
    check_eq("arst_rdata", mem_rdata, 0);
    check_eq("arst_stall", mem_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h5555_AAAA;
    #1;
    check_eq("stray_req", bus.data_req, 0);
    check_eq("stray_stall", mem_stall, 0);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    #1;
    check_eq("stray_rdata", mem_rdata, 0);
    check_eq("stray_req2", bus.data_req, 0);
    model_rdata = 32'h0;
  endtask

  initial begin
    int a, d, adv, fa;
    rst = 1'b1;
    mem_req = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; mem_offset = 2'b00;
    mem_addr = 32'h0; mem_wdata = 32'h0; pipe_adv = 1'b0; flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", bus.data_req, 0);
    check_eq("rst_wr", bus.data_wr, 0);
    check_eq("rst_size", bus.data_size, 0);
    check_eq("rst_addr", bus.data_addr, 0);
    check_eq("rst_wdata", bus.data_wdata, 0);
    check_eq("rst_rdata", mem_rdata, 0);
    check_eq("rst_stall", mem_stall, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, 2'b10, 32'h8000_0104, 2'b00, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, -1, 1'b0);
    run_txn(1'b1, 2'b00, 32'h8000_0200, 2'b11, 32'hAB00_0000, 32'h0, 4, 0, 0, -1, 1'b0);
    run_txn(1'b0, 2'b10, 32'h8000_0300, 2'b00, 32'h0, 32'h0000_1234, 2, 0, 0, 1, 1'b0);
    run_txn(1'b0, 2'b10, 32'h8000_0400, 2'b00, 32'h0, 32'h7777_0000, 0, 2, 0, 1, 1'b1);
    run_txn(1'b0, 2'b01, 32'h8000_0500, 2'b10, 32'h0, 32'h0BAD_F00D, 1, 1, 3, -1, 1'b0);
    reset_mid_data();

    for (int n = 0; n < 300; n++) begin
      a   = $urandom_range(3);
      d   = $urandom_range(3);
      adv = $urandom_range(2);
      fa  = ($urandom_range(3) == 0) ? $urandom_range(a + d + 1) : -1;
      run_txn($urandom_range(1), 2'($urandom_range(3)), $urandom, 2'($urandom_range(3)),
              $urandom, $urandom, a, d, adv, fa, 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
